// File: rtl/pmem_responder.sv
// Fixed-latency data-memory responder: one outstanding request, 64-bit word storage,
// low-aligned byte-masked loads and stores, registered response held until accepted.
module pmem_responder #(
   parameter logic [63:0] BASE    = 64'h8000_0000,
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [63:0] req_addr,
   input  logic        req_wen,
   input  logic [63:0] req_wdata,
   input  logic [7:0]  req_mask,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned IdxW        = $clog2(DEPTH);
   localparam logic [63:0] Span        = 64'(DEPTH) << 3;
   localparam logic [3:0]  CntInit     = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
   localparam bit          SingleCycle = (LATENCY == 1);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic [63:0] addr_q;
   logic        wen_q;
   logic [63:0] wdata_q;
   logic [7:0]  mask_q;
   logic        resp_valid_q;
   logic [63:0] rdata_q;
   logic        err_q;

   logic [63:0] mem_q [DEPTH];

   logic [63:0]     acc_addr;
   logic            acc_wen;
   logic [63:0]     acc_wdata;
   logic [7:0]      acc_mask;
   logic [63:0]     off;
   logic            in_range;
   logic [IdxW-1:0] idx;
   logic [2:0]      byte_off;
   logic [63:0]     word;
   logic [7:0]      smask;
   logic [63:0]     sdata;
   logic [63:0]     shifted;
   logic [63:0]     merged;
   logic [63:0]     load_data;
   logic [63:0]     acc_rdata;
   logic            acc_err;
   logic            do_access;
   logic            do_write;

   assign req_ready  = (state_q == StIdle) && !reset;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   // A single-cycle build performs the access on the accepting edge, straight from the inputs.
   always_comb begin
      acc_addr  = (state_q == StIdle) ? req_addr  : addr_q;
      acc_wen   = (state_q == StIdle) ? req_wen   : wen_q;
      acc_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
      acc_mask  = (state_q == StIdle) ? req_mask  : mask_q;
      off       = acc_addr - BASE;
      in_range  = (acc_addr >= BASE) && (off < Span);
      idx       = off[IdxW+2:3];
      byte_off  = acc_addr[2:0];
      word      = mem_q[idx];
      smask     = acc_mask << byte_off;
      sdata     = acc_wdata << {byte_off, 3'b000};
      shifted   = word >> {byte_off, 3'b000};
      merged    = word;
      load_data = '0;
      for (int b = 0; b < 8; b++) begin
         if (smask[b]) merged[8*b +: 8] = sdata[8*b +: 8];
         if (acc_mask[b]) load_data[8*b +: 8] = shifted[8*b +: 8];
      end
      acc_rdata = (in_range && !acc_wen) ? load_data : 64'h0;
      acc_err   = !in_range;
      do_access = SingleCycle ? (req_valid && req_ready)
                              : ((state_q == StWait) && (cnt_q == 4'd0));
      do_write  = do_access && in_range && acc_wen;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         cnt_q        <= 4'd0;
         addr_q       <= '0;
         wen_q        <= 1'b0;
         wdata_q      <= '0;
         mask_q       <= '0;
         resp_valid_q <= 1'b0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  addr_q  <= req_addr;
                  wen_q   <= req_wen;
                  wdata_q <= req_wdata;
                  mask_q  <= req_mask;
                  if (SingleCycle) begin
                     state_q      <= StResp;
                     resp_valid_q <= 1'b1;
                     rdata_q      <= acc_rdata;
                     err_q        <= acc_err;
                  end else begin
                     state_q <= StWait;
                     cnt_q   <= CntInit;
                  end
               end
            end
            StWait: begin
               if (cnt_q == 4'd0) begin
                  state_q      <= StResp;
                  resp_valid_q <= 1'b1;
                  rdata_q      <= acc_rdata;
                  err_q        <= acc_err;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StResp: begin
               if (resp_ready) begin
                  state_q      <= StIdle;
                  resp_valid_q <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clock) begin
      if (do_write) mem_q[idx] <= merged;
   end

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: a LATENCY=2 instance for function, backpressure and reset,
// and a LATENCY=1 instance for back-to-back throughput.
module tb_pmem_responder;

   logic clk;
   logic reset;

   logic        req_valid, req_ready, req_wen, resp_valid, resp_ready, resp_err;
   logic [63:0] req_addr, req_wdata, resp_rdata;
   logic [7:0]  req_mask;

   logic        f_req_valid, f_req_ready, f_req_wen, f_resp_valid, f_resp_ready, f_resp_err;
   logic [63:0] f_req_addr, f_req_wdata, f_resp_rdata;
   logic [7:0]  f_req_mask;

   int n_vec;
   int n_err;

   pmem_responder #(.BASE(64'h8000_0000), .DEPTH(256), .LATENCY(2)) u_dut (
      .clock      (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_wen    (req_wen),
      .req_wdata  (req_wdata),
      .req_mask   (req_mask),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   pmem_responder #(.BASE(64'h8000_0000), .DEPTH(256), .LATENCY(1)) u_dut_fast (
      .clock      (clk),
      .reset      (reset),
      .req_valid  (f_req_valid),
      .req_ready  (f_req_ready),
      .req_addr   (f_req_addr),
      .req_wen    (f_req_wen),
      .req_wdata  (f_req_wdata),
      .req_mask   (f_req_mask),
      .resp_valid (f_resp_valid),
      .resp_ready (f_resp_ready),
      .resp_rdata (f_resp_rdata),
      .resp_err   (f_resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present a request, wait for acceptance, scramble inputs, then wait for resp_valid.
   // lat counts rising edges from the accepting edge up to the one after which resp_valid is seen.
   task automatic issue(input logic [63:0] a, input logic w, input logic [63:0] d,
                        input logic [7:0] m, output int lat);
      req_addr  = a;
      req_wen   = w;
      req_wdata = d;
      req_mask  = m;
      req_valid = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = 64'h8000_0010;
      req_wen   = ~w;
      req_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
      req_mask  = 8'h5A;
      lat = 1;
      @(negedge clk);
      while (!resp_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic txn(input logic [63:0] a, input logic w, input logic [63:0] d,
                      input logic [7:0] m, output logic [63:0] rd, output logic er,
                      output int lat);
      issue(a, w, d, m, lat);
      rd = resp_rdata;
      er = resp_err;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #2 reset = 1'b1;
      #1;
      n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
      n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
      n_vec++; if (resp_rdata !== 64'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
      n_vec++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", resp_err); end
      n_vec++; if (f_req_ready !== 1'b0) begin n_err++; $display("FAIL rst_f_req_ready: got %b want 0", f_req_ready); end
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
      n_vec++; if (f_req_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_f_ready: got %b want 1", f_req_ready); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_store_load();
      logic [63:0] rd;
      logic        er;
      int          lat;
      txn(64'h8000_0000, 1'b1, 64'h1122_3344_5566_7788, 8'hFF, rd, er, lat);
      n_vec++; if (lat != 2) begin n_err++; $display("FAIL st_latency: got %0d want 2", lat); end
      n_vec++; if (er !== 1'b0) begin n_err++; $display("FAIL st_err: got %b want 0", er); end
      n_vec++; if (rd !== 64'h0) begin n_err++; $display("FAIL st_rdata: got %h want 0", rd); end
      txn(64'h8000_0000, 1'b0, 64'h0, 8'hFF, rd, er, lat);
      n_vec++; if (lat != 2) begin n_err++; $display("FAIL ld_latency: got %0d want 2", lat); end
      n_vec++; if (er !== 1'b0) begin n_err++; $display("FAIL ld_err: got %b want 0", er); end
      n_vec++; if (rd !== 64'h1122_3344_5566_7788) begin n_err++; $display("FAIL ld_rdata: got %h want 1122334455667788", rd); end
   endtask

   task automatic test_byte_merge();
      logic [63:0] rd;
      logic        er;
      int          lat;
      txn(64'h8000_0005, 1'b1, 64'h0000_0000_0000_00AB, 8'h01, rd, er, lat);
      txn(64'h8000_0000, 1'b0, 64'h0, 8'hFF, rd, er, lat);
      n_vec++; if (rd !== 64'h1122_AB44_5566_7788) begin n_err++; $display("FAIL merge_word: got %h want 1122ab4455667788", rd); end
      txn(64'h8000_0004, 1'b0, 64'h0, 8'h03, rd, er, lat);
      n_vec++; if (rd !== 64'h0000_0000_0000_AB44) begin n_err++; $display("FAIL merge_partial: got %h want 000000000000ab44", rd); end
      // Mask bits pushed past byte 7 are dropped: only bytes 6 and 7 change.
      txn(64'h8000_0006, 1'b1, 64'h0000_0000_DDCC_BBAA, 8'h0F, rd, er, lat);
      n_vec++; if (er !== 1'b0) begin n_err++; $display("FAIL mask_ovf_err: got %b want 0", er); end
      txn(64'h8000_0000, 1'b0, 64'h0, 8'hFF, rd, er, lat);
      n_vec++; if (rd !== 64'hBBAA_AB44_5566_7788) begin n_err++; $display("FAIL mask_ovf_word: got %h want bbaaab4455667788", rd); end
   endtask

   task automatic test_out_of_range();
      logic [63:0] rd;
      logic        er;
      int          lat;
      txn(64'h8000_0800, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er, lat);
      n_vec++; if (er !== 1'b1) begin n_err++; $display("FAIL oor_st_err: got %b want 1", er); end
      n_vec++; if (rd !== 64'h0) begin n_err++; $display("FAIL oor_st_rdata: got %h want 0", rd); end
      txn(64'h8000_0000, 1'b0, 64'h0, 8'hFF, rd, er, lat);
      n_vec++; if (rd !== 64'hBBAA_AB44_5566_7788) begin n_err++; $display("FAIL oor_word0: got %h want bbaaab4455667788", rd); end
      txn(64'h7FFF_FFF8, 1'b0, 64'h0, 8'hFF, rd, er, lat);
      n_vec++; if (er !== 1'b1) begin n_err++; $display("FAIL oor_ld_err: got %b want 1", er); end
      n_vec++; if (rd !== 64'h0) begin n_err++; $display("FAIL oor_ld_rdata: got %h want 0", rd); end
      txn(64'h8000_07F8, 1'b1, 64'h5A5A_0F0F_A5A5_F0F0, 8'hFF, rd, er, lat);
      n_vec++; if (er !== 1'b0) begin n_err++; $display("FAIL top_st_err: got %b want 0", er); end
      txn(64'h8000_07F8, 1'b0, 64'h0, 8'hFF, rd, er, lat);
      n_vec++; if (rd !== 64'h5A5A_0F0F_A5A5_F0F0) begin n_err++; $display("FAIL top_ld_rdata: got %h want 5a5a0f0fa5a5f0f0", rd); end
   endtask

   task automatic test_backpressure();
      logic [63:0] rd;
      logic        er;
      int          lat;
      resp_ready = 1'b0;
      issue(64'h8000_0000, 1'b0, 64'h0, 8'hFF, lat);
      n_vec++; if (lat != 2) begin n_err++; $display("FAIL bp_latency: got %0d want 2", lat); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         req_valid = (i == 1);
         req_wen   = 1'b1;
         req_addr  = 64'h8000_0000;
         req_wdata = 64'h0;
         req_mask  = 8'hFF;
         @(negedge clk);
         n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", i, resp_valid); end
         n_vec++; if (resp_rdata !== 64'hBBAA_AB44_5566_7788) begin n_err++; $display("FAIL bp_rdata[%0d]: got %h want bbaaab4455667788", i, resp_rdata); end
         n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_req_ready[%0d]: got %b want 0", i, req_ready); end
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL bp_done_valid: got %b want 0", resp_valid); end
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_done_ready: got %b want 1", req_ready); end
      txn(64'h8000_0000, 1'b0, 64'h0, 8'hFF, rd, er, lat);
      n_vec++; if (rd !== 64'hBBAA_AB44_5566_7788) begin n_err++; $display("FAIL bp_ignored_store: got %h want bbaaab4455667788", rd); end
      n_vec++; if (lat != 2) begin n_err++; $display("FAIL bp_after_latency: got %0d want 2", lat); end
   endtask

   task automatic test_reset_mid_wait();
      logic [63:0] rd;
      logic        er;
      int          lat;
      txn(64'h8000_0008, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, rd, er, lat);
      txn(64'h8000_0008, 1'b0, 64'h0, 8'hFF, rd, er, lat);
      n_vec++; if (rd !== 64'h0123_4567_89AB_CDEF) begin n_err++; $display("FAIL rmw_pre: got %h want 0123456789abcdef", rd); end
      req_addr  = 64'h8000_0008;
      req_wen   = 1'b1;
      req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      req_mask  = 8'hFF;
      req_valid = 1'b1;
      @(negedge clk);
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rmw_accept_ready: got %b want 1", req_ready); end
      @(posedge clk);
      #3;
      req_valid = 1'b0;
      reset     = 1'b1;
      #1;
      n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rmw_req_ready: got %b want 0", req_ready); end
      n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rmw_resp_valid: got %b want 0", resp_valid); end
      n_vec++; if (resp_rdata !== 64'h0) begin n_err++; $display("FAIL rmw_rdata: got %h want 0", resp_rdata); end
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rmw_no_resp: got %b want 0", resp_valid); end
      @(posedge clk);
      #1;
      txn(64'h8000_0008, 1'b0, 64'h0, 8'hFF, rd, er, lat);
      n_vec++; if (rd === 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL rmw_discard: got %h want not ffffffffffffffff", rd); end
      n_vec++; if (rd !== 64'h0123_4567_89AB_CDEF) begin n_err++; $display("FAIL rmw_kept: got %h want 0123456789abcdef", rd); end
   endtask

   // LATENCY=1 instance with req_valid held high: one access every 2 cycles.
   task automatic test_back_to_back();
      logic [63:0] ad [8];
      logic        we [8];
      logic [63:0] wd [8];
      logic [7:0]  mk [8];
      logic [63:0] ex [8];
      ad = '{64'h8000_0000, 64'h8000_0008, 64'h8000_0010, 64'h8000_0018,
             64'h8000_0000, 64'h8000_0009, 64'h8000_0012, 64'h8000_001F};
      we = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      wd = '{64'h0F1E_2D3C_4B5A_6978, 64'hA1B2_C3D4_E5F6_0718,
             64'h1111_2222_3333_4444, 64'hCAFE_BABE_DEAD_BEEF,
             64'h0, 64'h0, 64'h0, 64'h0};
      mk = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h07, 8'h03, 8'h01};
      ex = '{64'h0, 64'h0, 64'h0, 64'h0,
             64'h0F1E_2D3C_4B5A_6978, 64'h0000_0000_00E5_F607,
             64'h0000_0000_0000_3333, 64'h0000_0000_0000_00CA};
      f_req_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         f_req_addr  = ad[k];
         f_req_wen   = we[k];
         f_req_wdata = wd[k];
         f_req_mask  = mk[k];
         @(negedge clk);
         n_vec++; if (f_req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, f_req_ready); end
         @(posedge clk);
         #1;
         @(negedge clk);
         n_vec++; if (f_resp_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, f_resp_valid); end
         n_vec++; if (f_resp_rdata !== ex[k]) begin n_err++; $display("FAIL b2b_rdata[%0d]: got %h want %h", k, f_resp_rdata, ex[k]); end
         n_vec++; if (f_resp_err !== 1'b0) begin n_err++; $display("FAIL b2b_err[%0d]: got %b want 0", k, f_resp_err); end
         n_vec++; if (f_req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_busy[%0d]: got %b want 0", k, f_req_ready); end
         @(posedge clk);
         #1;
      end
      f_req_valid = 1'b0;
      @(negedge clk);
      n_vec++; if (f_resp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", f_resp_valid); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_vec        = 0;
      n_err        = 0;
      req_valid    = 1'b0;
      req_addr     = '0;
      req_wen      = 1'b0;
      req_wdata    = '0;
      req_mask     = '0;
      resp_ready   = 1'b1;
      f_req_valid  = 1'b0;
      f_req_addr   = '0;
      f_req_wen    = 1'b0;
      f_req_wdata  = '0;
      f_req_mask   = '0;
      f_resp_ready = 1'b1;
      test_reset();
      test_store_load();
      test_byte_merge();
      test_out_of_range();
      test_backpressure();
      test_reset_mid_wait();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
